// File: rtl/ysyx_imem_resp_if.sv
// Fetch bus between the IFU and the instruction memory model, plus the loader preload port.
// The IFU/loader side drives requests and preload writes; the memory side returns rdata/rvalid/rerr.
interface ysyx_imem_resp_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              rerr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output araddr, arvalid, wr_en, wr_addr, wr_data,
    input  arready, rdata, rvalid, rerr
  );

  modport slave (
    input  araddr, arvalid, wr_en, wr_addr, wr_data,
    output arready, rdata, rvalid, rerr
  );
endinterface

// File: rtl/ysyx_imem_resp.sv
// Instruction SRAM model answering IFU fetches: rvalid pulses LATENCY cycles after acceptance, one fetch outstanding.
// No rready: the IFU must take the one-cycle pulse; YSYX_IMEM_RAND_DELAY_EN adds 0..7 LFSR-driven extra cycles.
module ysyx_imem_resp #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                MEM_DEPTH = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h8000_0000),
  parameter int                LATENCY   = 2
) (
  input  logic             clk,
  input  logic             rst,
  ysyx_imem_resp_if.slave  bus
);
  localparam int                IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(4 * MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_accept;
  logic [ADDR_W-1:0] r_addr;
  logic [4:0]        r_cnt;
  logic [4:0]        w_total;
  logic [2:0]        w_extra;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rerr;
  logic [DATA_W-1:0] r_mem [MEM_DEPTH];

  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] w_rd_off;
  logic              w_rd_ok;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [ADDR_W-1:0] w_wr_off;
  logic              w_wr_ok;
  logic [IDX_W-1:0]  w_wr_idx;

`ifdef YSYX_IMEM_RAND_DELAY_EN
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end

  assign w_extra = r_lfsr[2:0];
`else
  assign w_extra = 3'd0;
`endif

  // Total cycles from acceptance to rvalid; the counter holds the WAIT cycles still to go after the next one.
  assign w_total = 5'(LATENCY) + {2'b00, w_extra};

  // With a total latency of 1 the read happens on the acceptance edge, before r_addr is loaded.
  assign w_rd_addr = (r_state == IDLE) ? bus.araddr : r_addr;
  assign w_rd_off  = w_rd_addr - BASE_ADDR;
  assign w_rd_ok   = (w_rd_off < SPAN) && (w_rd_addr[1:0] == 2'b00);
  assign w_rd_idx  = w_rd_off[IDX_W+1:2];

  assign w_wr_off  = bus.wr_addr - BASE_ADDR;
  assign w_wr_ok   = (w_wr_off < SPAN) && (bus.wr_addr[1:0] == 2'b00);
  assign w_wr_idx  = w_wr_off[IDX_W+1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.arvalid) begin
          w_accept    = 1'b1;
          w_state_nxt = (w_total == 5'd1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == 5'd0) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_cnt   <= 5'd0;
      r_rdata <= '0;
      r_rerr  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr <= bus.araddr;
        r_cnt  <= w_total - 5'd2;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 5'd1;
      end

      // Read on the edge that raises rvalid; a same-edge preload write lands after this sample.
      if (w_state_nxt == RESP) begin
        r_rerr  <= ~w_rd_ok;
        r_rdata <= w_rd_ok ? r_mem[w_rd_idx] : '0;
      end else begin
        r_rerr  <= 1'b0;
        r_rdata <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.wr_en && w_wr_ok) begin
      r_mem[w_wr_idx] <= bus.wr_data;
    end
  end

  assign bus.arready = (r_state == IDLE) && !rst;
  assign bus.rvalid  = (r_state == RESP);
  assign bus.rdata   = r_rdata;
  assign bus.rerr    = r_rerr;
endmodule

// File: tb/tb_ysyx_imem_resp.sv
// Bench for ysyx_imem_resp: directed steps then random fetches against a word-array memory model.
module tb_ysyx_imem_resp;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] model_mem [DEPTH];

  always #5 clk = ~clk;

  ysyx_imem_resp_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ysyx_imem_resp #(
    .ADDR_W(32), .DATA_W(32), .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A word is mapped only if aligned and inside the BASE..BASE+4*DEPTH window.
  function automatic logic mapped(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(4 * DEPTH)) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return mapped(a) ? model_mem[int'(off / 4)] : 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] off;
    off = a - BASE;
    if (mapped(a)) model_mem[int'(off / 4)] = d;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    model_write(a, d);
    step();
    bus.wr_en = 1'b0;
  endtask

  // Single fetch from IDLE: accept now, change araddr next cycle, expect the pulse LAT cycles later.
  task automatic fetch(input logic [31:0] a, input logic [31:0] alt, input string tag);
    logic [31:0] exp_d;
    logic        exp_e;
    exp_d = model_read(a);
    exp_e = !mapped(a);
    bus.arvalid = 1'b1;
    bus.araddr  = a;
    chk({tag, ".arready_T"}, 32'(bus.arready), 32'd1);
    step();
    bus.arvalid = 1'b0;
    bus.araddr  = alt;
    chk({tag, ".rvalid_T1"}, 32'(bus.rvalid), 32'd0);
    step();
    chk({tag, ".rvalid_T2"}, 32'(bus.rvalid), 32'd1);
    chk({tag, ".rdata"}, bus.rdata, exp_d);
    chk({tag, ".rerr"}, 32'(bus.rerr), 32'(exp_e));
    step();
    chk({tag, ".rvalid_T3"}, 32'(bus.rvalid), 32'd0);
    chk({tag, ".rdata_T3"}, bus.rdata, 32'd0);
    chk({tag, ".arready_T3"}, 32'(bus.arready), 32'd1);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned sel;
    sel = $urandom_range(0, 9);
    if (sel < 6)       return BASE + 32'($urandom_range(0, DEPTH - 1)) * 4;
    else if (sel < 8)  return BASE + 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
    else if (sel == 8) return BASE - 32'($urandom_range(1, 1000)) * 4;
    else               return BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 1000)) * 4;
  endfunction

  initial begin
    logic [31:0] q_addr [$];
    logic [31:0] a;
    logic [31:0] exp_d;

    rst         = 1'b1;
    bus.arvalid = 1'b0;
    bus.araddr  = '0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    step();
    chk("rst.arready", 32'(bus.arready), 32'd0);
    chk("rst.rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst.rdata", bus.rdata, 32'd0);
    chk("rst.rerr", 32'(bus.rerr), 32'd0);

    // Preload during reset with arvalid asserted; the request must be ignored.
    bus.arvalid = 1'b1;
    bus.araddr  = BASE;
    wr(BASE,       32'h0000_0413);
    wr(BASE + 4,   32'hDEAD_BEEF);
    wr(BASE + 8,   32'h0010_0093);
    chk("rst.arready_hold", 32'(bus.arready), 32'd0);
    bus.arvalid = 1'b0;
    rst         = 1'b0;
    step();
    chk("post_rst.arready", 32'(bus.arready), 32'd1);
    chk("post_rst.rvalid", 32'(bus.rvalid), 32'd0);
    step();
    chk("post_rst.rvalid2", 32'(bus.rvalid), 32'd0);

    fetch(BASE, BASE, "t1");
    fetch(BASE, BASE + 4, "t2");
    fetch(32'h7FFF_FFFC, BASE, "t3.below");
    fetch(32'h8000_1000, BASE, "t3.above");
    fetch(32'h8000_0002, BASE, "t3.misal");
    wr(BASE + 32'hFFC, 32'hCAFE_F00D);
    fetch(BASE + 32'hFFC, BASE, "t3.last");

    // Writes outside the window or misaligned must not reach any word.
    wr(32'h8000_1000, 32'hBADB_AD00);
    wr(BASE + 1,      32'hBADB_AD01);
    wr(32'h7FFF_FFFC, 32'hBADB_AD02);
    fetch(BASE, BASE, "drop.w0");
    fetch(BASE + 4, BASE, "drop.w1");

    // Back-to-back with arvalid held: one acceptance every LAT+1 cycles.
    bus.arvalid = 1'b1;
    bus.araddr  = BASE;
    for (int k = 0; k < 3 * (LAT + 1); k++) begin
      chk($sformatf("t4.arready%0d", k), 32'(bus.arready), 32'((k % (LAT + 1)) == 0));
      chk($sformatf("t4.rvalid%0d", k), 32'(bus.rvalid), 32'((k % (LAT + 1)) == LAT));
      if ((k % (LAT + 1)) == LAT && q_addr.size() > 0) begin
        a = q_addr.pop_front();
        chk($sformatf("t4.rdata%0d", k), bus.rdata, model_read(a));
      end else begin
        chk($sformatf("t4.rdata_idle%0d", k), bus.rdata, 32'd0);
      end
      if ((k % (LAT + 1)) == 0) q_addr.push_back(bus.araddr);
      step();
      if (((k % (LAT + 1)) == 0)) bus.araddr = bus.araddr + 32'd4;
    end
    bus.arvalid = 1'b0;
    chk("t4.queue_drained", 32'(q_addr.size()), 32'd0);

    // Reset one cycle after acceptance drops the fetch.
    bus.arvalid = 1'b1;
    bus.araddr  = BASE + 8;
    step();
    bus.arvalid = 1'b0;
    rst         = 1'b1;
    step();
    rst = 1'b0;
    chk("t5.no_rvalid", 32'(bus.rvalid), 32'd0);
    chk("t5.rdata", bus.rdata, 32'd0);
    step();
    fetch(BASE + 8, BASE, "t5.after");
    fetch(BASE, BASE, "t5.intact");

    // Write before the read edge is seen; write on the read edge is not.
    bus.arvalid = 1'b1;
    bus.araddr  = BASE;
    bus.wr_en   = 1'b1;
    bus.wr_addr = BASE;
    bus.wr_data = 32'h1111_1111;
    model_write(BASE, 32'h1111_1111);
    step();
    bus.arvalid = 1'b0;
    bus.wr_data = 32'h2222_2222;
    chk("t6.rvalid_T1", 32'(bus.rvalid), 32'd0);
    step();
    model_write(BASE, 32'h2222_2222);
    bus.wr_en = 1'b0;
    chk("t6.rvalid_T2", 32'(bus.rvalid), 32'd1);
    chk("t6.rdata_old", bus.rdata, 32'h1111_1111);
    step();
    fetch(BASE, BASE, "t6.new");
    chk("t6.model_new", model_read(BASE) ^ 32'h2222_2222, 32'd0);

    // Random preload of every word, then random fetches interleaved with random writes.
    for (int i = 0; i < DEPTH; i++) wr(BASE + 32'(i) * 4, $urandom);
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 1) wr(rand_addr(), $urandom);
      a = rand_addr();
      exp_d = model_read(a);
      fetch(a, $urandom, $sformatf("rnd%0d@%h", n, a));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
